seq_div: RTL and testbench
==========================

Name: seq_div

Overview:
- Iterative restoring divider; the inverse companion of the combinational array multiplier.
- Computes quotient and remainder of two unsigned WIDTH-bit operands, one quotient bit per clock.
- Uses a start/busy/done handshake so it can sit behind a register-file or test controller in the digital-logic block library.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- dividend  in  WIDTH  numerator; latched when start is accepted.
- divisor  in  WIDTH  denominator; latched when start is accepted.
- busy  out  1  high in RUN and DONE states.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.
- div_zero  out  1  latched divisor==0 indication for the last operation.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - busy, done, div_zero = 0.
  - quotient, remainder = 0.
  - Internal partial remainder, shift register and counter = 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Latch dividend into the shift register and divisor into the divisor register.
  - Clear the partial remainder P (WIDTH+1 bits) and the counter.
  - Set div_zero = (divisor==0).
  - Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - Shift: P' = {P[WIDTH-1:0], shift_msb}.
  - Trial: T = P' − {0,divisor}, computed at WIDTH+1 bits.
  - If T has no borrow (T[WIDTH]==0): P = T, shift in quotient bit 1.
  - Otherwise: P = P', shift in quotient bit 0.
  - Quotient bits enter the shift register LSB as dividend bits leave its MSB.
  - Counter increments.
  - On the WIDTH-th RUN edge (edge k+WIDTH):
    - Load quotient = shift register result and remainder = P[WIDTH-1:0].
    - Go to DONE.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE with done=0.
- Latency: start at edge k → done high during the cycle after edge k+WIDTH. busy is high from after edge k until edge k+WIDTH+1.
- start while busy=1 (RUN or DONE) is ignored, with no effect on operands or results.
- quotient, remainder and div_zero hold their values until the next accepted operation loads new results.
  - div_zero updates at acceptance.
  - quotient and remainder update only at completion.
- Divide by zero (default algorithm): quotient = all ones, remainder = dividend, div_zero=1, full WIDTH-cycle latency.
- Boundary values:
  - dividend < divisor: quotient 0, remainder = dividend.
  - divisor 1: quotient = dividend, remainder 0.
  - dividend 0: both results 0.
- Reset asserted mid-RUN or in DONE:
  - Immediate return to IDLE with all outputs 0.
  - The in-flight operation is discarded and no done pulse is produced.

Optional Feature:
- Macro: DIV_ZERO_SHORTCUT_EN.
- Defined: a start accepted with divisor==0 goes directly to DONE at the next edge, skipping RUN.
  - done is high during the cycle after edge k+1.
  - quotient = all ones, remainder = dividend, div_zero=1.
  - Latency for nonzero divisors is unchanged.
- Undefined: divide by zero runs the normal WIDTH-cycle restoring sequence. Result values and div_zero are identical to the defined case; only latency differs.

Decomposition:
- Shared include div_defs.vh:
  - State encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter-width constant derived from WIDTH (clog2(WIDTH+1)).
- One natural sub-module, div_step: combinational single restoring step.
  - Inputs: P, shift_msb, divisor.
  - Outputs: next P, quotient bit.
  - Instantiated once inside seq_div and unit-testable on its own.

Test Plan:
- WIDTH=4, dividend=13, divisor=3, start pulse → busy next cycle; done exactly 5 cycles after the start edge; quotient=4, remainder=1, div_zero=0.
- Sweep: 15/1 → q=15, r=0; 2/7 → q=0, r=2; 0/5 → q=0, r=0; 15/15 → q=1, r=0.
- 9/0:
  - Without macro: done 5 cycles after start; q=15, r=9, div_zero=1.
  - With DIV_ZERO_SHORTCUT_EN: done 2 cycles after start, same values.
- Start 13/3, then pulse start with 7/2 during RUN and again in DONE → both ignored; result stays q=4, r=1; single done pulse.
- Start 14/4, assert rst_n=0 two cycles later → busy, done, quotient, remainder, div_zero all 0 immediately; no done after release; a following 14/4 gives q=3, r=2.
- Exhaustive 256-pair sweep at WIDTH=4 against a reference model, back-to-back (start issued the cycle after done) → all match; latency constant.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared definitions for the seq_div restoring divider: FSM state codes and counter sizing.
package seq_div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] p,
    input  logic             shift_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] p_next,
    output logic             q_bit
);

    logic [WIDTH:0] p_shift;
    logic [WIDTH:0] trial;

    always_comb begin
        p_shift = {p, shift_msb};
        trial   = p_shift - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        // Any kept value is below 2^WIDTH, so the extra trial bit can be dropped.
        p_next  = q_bit ? trial[WIDTH-1:0] : p_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor finishes after one RUN edge instead of WIDTH.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_next;
    logic             q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p        (p),
        .shift_msb(sh[WIDTH-1]),
        .divisor  (dvs),
        .p_next   (p_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            p         <= '0;
            sh        <= '0;
            dvs       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh       <= dividend;
                        dvs      <= divisor;
                        p        <= '0;
                        cnt      <= '0;
                        div_zero <= (divisor == '0);
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
`ifdef DIV_ZERO_SHORTCUT_EN
                    if (div_zero) begin
                        // Shift register still holds the untouched dividend on the first RUN edge.
                        quotient  <= '1;
                        remainder <= sh;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
`else
                    begin
`endif
                        p   <= p_next;
                        sh  <= {sh[WIDTH-2:0], q_bit};
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            quotient  <= {sh[WIDTH-2:0], q_bit};
                            remainder <= p_next;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (WIDTH=4) against a plain-arithmetic division model.
// Honours DIV_ZERO_SHORTCUT_EN for the expected zero-divisor latency.
module tb_seq_div;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_div #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_q(input int unsigned a, input int unsigned b);
        return (b == 0) ? (1 << WIDTH) - 1 : a / b;
    endfunction

    function automatic int unsigned ref_r(input int unsigned a, input int unsigned b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int unsigned ref_lat(input int unsigned b);
`ifdef DIV_ZERO_SHORTCUT_EN
        return (b == 0) ? 1 : WIDTH;
`else
        return (b == 0) ? WIDTH : WIDTH;
`endif
    endfunction

    // Issue one operation; optionally hold start high with other operands through RUN and DONE.
    task automatic run_op(input int unsigned a, input int unsigned b, input bit inject);
        int unsigned lat;
        bit seen;
        @(negedge clk);
        start    = 1'b1;
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        @(posedge clk);
        #1;
        check("busy_after_start", 32'(busy), 1);
        if (inject) begin
            dividend = 4'd7;
            divisor  = 4'd2;
        end else begin
            start    = 1'b0;
            dividend = WIDTH'($urandom);
            divisor  = WIDTH'($urandom);
        end
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1'b1;
        end
        check("latency", lat, ref_lat(b));
        check("quotient", 32'(quotient), ref_q(a, b));
        check("remainder", 32'(remainder), ref_r(a, b));
        check("div_zero", 32'(div_zero), (b == 0) ? 1 : 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 0);
        check("busy_after_done", 32'(busy), 0);
        start = 1'b0;
        if (inject) begin
            @(posedge clk);
            #1;
            check("ignored_start_busy", 32'(busy), 0);
            check("ignored_start_q", 32'(quotient), ref_q(a, b));
            check("ignored_start_r", 32'(remainder), ref_r(a, b));
        end
    endtask

    initial begin
        int unsigned done_seen;

        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_q", 32'(quotient), 0);
        check("rst_r", 32'(remainder), 0);
        check("rst_dz", 32'(div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(13, 3, 1'b0);
        run_op(15, 1, 1'b0);
        run_op(2, 7, 1'b0);
        run_op(0, 5, 1'b0);
        run_op(15, 15, 1'b0);
        run_op(9, 0, 1'b0);
        run_op(13, 3, 1'b1);
        run_op(9, 0, 1'b0);

        // Reset two edges into a 14/4 operation.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(busy), 0);
        check("midrun_rst_done", 32'(done), 0);
        check("midrun_rst_q", 32'(quotient), 0);
        check("midrun_rst_r", 32'(remainder), 0);
        check("midrun_rst_dz", 32'(div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("no_done_after_rst", done_seen, 0);
        run_op(14, 4, 1'b0);

        for (int a = 0; a < (1 << WIDTH); a++)
            for (int b = 0; b < (1 << WIDTH); b++)
                run_op(a, b, 1'b0);

        for (int i = 0; i < 40; i++)
            run_op($urandom_range((1 << WIDTH) - 1), $urandom_range((1 << WIDTH) - 1), 1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
